regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Sequences and shares the single register-file write port (we/waddr/wdata) between NUM_REQ writeback requesters, e.g. ALU writeback and load writeback.
- After reset, and on request, it runs a clear sequence that writes zero to every register.
- In normal operation it grants one valid requester per cycle using round-robin.
- It drives registered write controls straight into the regfile.
- It sits between the writeback stage(s) and the regfile.

Parameters:
NUM_REQ, 2, number of write requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers cleared by clear sequence; must equal 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant; transfer when valid & ready
req_addr  input  NUM_REQ*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
clear_start  input  1  one-cycle pulse: re-run clear sequence
busy  output  1  high while clear sequence active
rf_we  output  1  regfile write enable (registered)
rf_waddr  output  ADDR_W  regfile write address (registered)
rf_wdata  output  DATA_W  regfile write data (registered)

Behaviour:
- One clock domain.
- Reset: rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values: state=CLEAR, clr_cnt=0, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0. busy is combinational, busy = (state==CLEAR), so busy=1 during reset.
- req_ready is combinational. It is all-zero whenever state==CLEAR.
- State machine, two states:
  - CLEAR: each cycle, register rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, and increment clr_cnt. On the cycle clr_cnt==NUM_REGS-1: clr_cnt wraps to 0 and next state = RUN.
  - Clear duration: exactly NUM_REGS write cycles. The first write lands at the first rising edge after rst_n deasserts.
  - RUN: grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ. At most one req_ready bit is high, and only for a valid requester. No valid requests gives req_ready=0.
- Transfer:
  - On a transfer, the next edge registers rf_waddr/rf_wdata from the granted requester.
  - rf_we=1 unless that address==0. Writes to $zero are accepted (ready asserted) but have rf_we=0.
  - Latency: request accepted in cycle N → regfile write in cycle N+1.
- Idle: with no transfer in RUN, rf_we=0 next cycle. rf_waddr/rf_wdata hold their last values.
- rr_ptr: after a transfer granted to requester g, rr_ptr ← (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- clear_start:
  - In RUN: the current cycle's grant still completes normally. Next state = CLEAR with clr_cnt=0.
  - In CLEAR: ignored; the count is not restarted.
- Requesters must hold valid/addr/data until ready. The arbiter never drops a request that has valid asserted and is not granted.
- Reset asserted mid-clear or mid-transfer: outputs return to reset values immediately. The pending transfer is lost. The clear sequence restarts from 0 after deassertion.

Optional Feature:
Macro: RFARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins. rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- CLEAR behaviour, latency and zero-address suppression are identical in both builds.

Test Plan:
- Reset release, no requests → busy=1 for 32 cycles. rf_we=1 with rf_waddr=0..31 and rf_wdata=0 on consecutive cycles. Then busy=0, rf_we=0.
- After clear, req0 valid, addr=5, data=10 → req_ready[0]=1 same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=10.
- req0 and req1 held valid for 4 cycles (req0 addr=6 data=1, req1 addr=7 data=2):
  - Default build: grants alternate 0,1,0,1; rf_waddr sequence 6,7,6,7.
  - RFARB_FIXED_PRIO_EN build: all four grants go to req0 (6,6,6,6).
- req1 valid, addr=0, data=0xFFFFFFFF → req_ready[1]=1, but next cycle rf_we=0.
- clear_start pulsed in RUN while req0 valid (addr=3, data=9):
  - The addr=3 write completes.
  - Next cycle busy=1 and req_ready=0 for 32 cycles, clearing 0..31.
  - A new req0 request held during the clear is granted on the first RUN cycle.
- rst_n asserted at clear count 10 → rf_we=0 asynchronously. After release, the clear restarts at rf_waddr=0 and again runs 32 cycles.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: clears all registers after reset or on request, then grants one writer per cycle.
// Build option RFARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module regfile_wr_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_start,
    output logic                      busy,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic                xfer;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

`ifdef RFARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan offsets from the far end so the nearest valid requester after rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = wrap_add(gnt_idx, 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign xfer = (state_q == ST_RUN) && gnt_found;
    assign busy = (state_q == ST_CLEAR);

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (state_q)
            ST_CLEAR: begin
                // clear_start is deliberately ignored here: the sweep never restarts mid-way.
                rf_we_d    = 1'b1;
                rf_waddr_d = clr_cnt_q;
                rf_wdata_d = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    rf_waddr_d = addr_arr[gnt_idx];
                    rf_wdata_d = data_arr[gnt_idx];
                    rf_we_d    = (addr_arr[gnt_idx] != '0);
                end
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table for RUN-mode arbitration plus hand sequences for clear/reset.
module tb_regfile_wr_arbiter;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic           clear_start;
    logic           busy;
    logic           rf_we;
    logic [AW-1:0]  rf_waddr;
    logic [DW-1:0]  rf_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clear_start(clear_start),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        clr;
        logic [1:0]  ready;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1, input logic clr,
                                input logic [1:0] r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd);
        vec_t t;
        t.valid = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.clr = clr;
        t.ready = r; t.we = we; t.waddr = wa; t.wdata = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic clr);
        req_valid   = v;
        req_addr    = {a1, a0};
        req_data    = {d1, d0};
        clear_start = clr;
    endtask

    // Entered 1 time unit after a rising edge; checks n clear writes and leaves 1 unit after the last edge.
    task automatic clear_run(input string tag, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            if (i == pulse_at) clear_start = 1'b1;
            #1;
            chk({tag, " busy"}, 64'(busy), 64'd1);
            chk({tag, " ready"}, 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            clear_start = 1'b0;
            chk({tag, " we"}, 64'(rf_we), 64'd1);
            chk({tag, " waddr"}, 64'(rf_waddr), 64'(i));
            chk({tag, " wdata"}, 64'(rf_wdata), 64'd0);
        end
    endtask

    initial begin
        tbl[0] = mk(2'b01, 5'd5, 32'd10, 5'd0, 32'd0, 1'b0, 2'b01, 1'b1, 5'd5, 32'd10);
        tbl[1] = mk(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 2'b10, 1'b0, 5'd0, 32'hFFFF_FFFF);
        tbl[2] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0, 32'hFFFF_FFFF);
`ifdef RFARB_FIXED_PRIO_EN
        tbl[3] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
        tbl[4] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
        tbl[5] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
        tbl[6] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
`else
        tbl[3] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
        tbl[4] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b10, 1'b1, 5'd7, 32'd2);
        tbl[5] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b01, 1'b1, 5'd6, 32'd1);
        tbl[6] = mk(2'b11, 5'd6, 32'd1, 5'd7, 32'd2, 1'b0, 2'b10, 1'b1, 5'd7, 32'd2);
`endif
        tbl[7] = mk(2'b10, 5'd0, 32'd0, 5'd9, 32'd3, 1'b0, 2'b10, 1'b1, 5'd9, 32'd3);
        tbl[8] = mk(2'b01, 5'd3, 32'd9, 5'd0, 32'd0, 1'b1, 2'b01, 1'b1, 5'd3, 32'd9);

        // Reset: ready must stay low even with requests present.
        rst_n = 1'b0;
        drive(2'b11, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0);
        #12;
        chk("rst busy", 64'(busy), 64'd1);
        chk("rst ready", 64'(req_ready), 64'd0);
        chk("rst we", 64'(rf_we), 64'd0);
        chk("rst waddr", 64'(rf_waddr), 64'd0);
        chk("rst wdata", 64'(rf_wdata), 64'd0);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_run("init clr", 32, -1);
        #1;
        chk("init done busy", 64'(busy), 64'd0);

        for (int v = 0; v < 9; v++) begin
            drive(tbl[v].valid, tbl[v].a0, tbl[v].d0, tbl[v].a1, tbl[v].d1, tbl[v].clr);
            #1;
            chk($sformatf("vec%0d ready", v), 64'(req_ready), 64'(tbl[v].ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d we", v), 64'(rf_we), 64'(tbl[v].we));
            chk($sformatf("vec%0d waddr", v), 64'(rf_waddr), 64'(tbl[v].waddr));
            chk($sformatf("vec%0d wdata", v), 64'(rf_wdata), 64'(tbl[v].wdata));
        end

        // Clear re-run with req0 held throughout; a clear_start mid-sweep must not restart the count.
        drive(2'b01, 5'd12, 32'h55, 5'd0, 32'd0, 1'b0);
        clear_run("reclr", 32, 5);
        #1;
        chk("reclr done busy", 64'(busy), 64'd0);
        chk("held req ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("held req we", 64'(rf_we), 64'd1);
        chk("held req waddr", 64'(rf_waddr), 64'd12);
        chk("held req wdata", 64'(rf_wdata), 64'h55);

        // Idle clear_start, then reset part-way through the sweep.
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        #1;
        chk("idle clr ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        chk("idle clr we", 64'(rf_we), 64'd0);
        chk("idle clr waddr hold", 64'(rf_waddr), 64'd12);
        clear_run("part clr", 10, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst we", 64'(rf_we), 64'd0);
        chk("async rst waddr", 64'(rf_waddr), 64'd0);
        chk("async rst busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("rst hold we", 64'(rf_we), 64'd0);
        rst_n = 1'b1;
        clear_run("post rst clr", 32, -1);
        #1;
        chk("post rst busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("post rst idle we", 64'(rf_we), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
